ahb_lite_arbiter: RTL and testbench
===================================

AHB_LITE_ARBITER -- requirements
Module: ahb_lite_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, 2, number of masters (legal 2..16).
REQ-002 Parameter AW, 32, address width.
REQ-003 Parameter DW, 32, write-data width.
REQ-004 Parameter ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 Parameter DEF_MASTER, 0, default/park master index.
REQ-006 HCLK  input  1  bus clock; all state changes on its rising edge.
REQ-007 HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-008 HBUSREQ  input  NUM_MASTERS  per-master bus request.
REQ-009 HLOCK  input  NUM_MASTERS  per-master locked-transfer request.
REQ-010 HTRANS_M  input  2*NUM_MASTERS  per-master HTRANS, master i at bits [2i+1:2i].
REQ-011 HADDR_M  input  AW*NUM_MASTERS  per-master address, packed as REQ-010.
REQ-012 HWRITE_M  input  NUM_MASTERS  per-master write flag.
REQ-013 HSIZE_M  input  2*NUM_MASTERS  per-master size.
REQ-014 HWDATA_M  input  DW*NUM_MASTERS  per-master write data.
REQ-015 HREADY  input  1  slave-side ready (HREADYout of the slave/decoder).
REQ-016 HGRANT  output  NUM_MASTERS  one-hot grant.
REQ-017 HMASTER  output  4  index of address-phase owner.
REQ-018 HMASTLOCK  output  1  current address phase is locked.
REQ-019 HTRANS, HADDR, HWRITE, HSIZE  output  2/AW/1/2  muxed address-phase signals to slaves.
REQ-020 HWDATA  output  DW  muxed data-phase write data.

Function
REQ-021 HGRANT, HMASTER, HMASTLOCK, HMASTER_D (internal data-phase owner) and last-served pointer LAST shall all be registered.
REQ-022 Arbitration point = rising edge with HREADY=1 and no hold condition; only there may HGRANT change.
REQ-023 Hold conditions: owner (HMASTER) driving HTRANS SEQ(11) or BUSY(01); or granted master's HLOCK=1 while it also has HBUSREQ=1.
REQ-024 ARB_MODE=0: grant lowest-index requester; ARB_MODE=1: grant first requester scanning LAST+1 upward with wrap from NUM_MASTERS-1 to 0.
REQ-025 No requester at arbitration point: grant DEF_MASTER (park).
REQ-026 LAST shall update to the newly granted index at each arbitration point where a requester won; unchanged on park.
REQ-027 On edge with HREADY=1: HMASTER <= index(HGRANT), HMASTLOCK <= HLOCK[index(HGRANT)], HMASTER_D <= HMASTER; ownership handover latency = 1 cycle after grant.
REQ-028 HREADY=0: HGRANT, HMASTER, HMASTER_D, HMASTLOCK, LAST hold.
REQ-029 HTRANS/HADDR/HWRITE/HSIZE shall be combinational mux of HMASTER's inputs; HWDATA combinational mux by HMASTER_D.
REQ-030 HMASTER index >= NUM_MASTERS cannot occur; outputs for such a value are don't-care.
REQ-031 Simultaneous requests under round-robin with owner still requesting: owner yields to next requester; owner re-wins only if sole requester.
REQ-032 Locked owner: grant held across HREADY=0 stretches until HLOCK or HBUSREQ deasserts, then normal arbitration resumes next point.

Reset
REQ-033 HRESETn=0 shall immediately force HGRANT=one-hot(DEF_MASTER), HMASTER=HMASTER_D=DEF_MASTER, HMASTLOCK=0, LAST=DEF_MASTER, regardless of HCLK or in-progress transfer.
REQ-034 First arbitration point shall be the first HCLK edge after HRESETn deasserts with HREADY=1.

Verification
REQ-035 Reset: assert HRESETn=0 mid-burst with NUM_MASTERS=4 -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0 without clock edge.
REQ-036 Round-robin: HBUSREQ=4'b1111 held, HTRANS NONSEQ singles, HREADY=1 -> grants cycle 1,2,3,0,1 on consecutive edges; HMASTER follows one cycle later; HWDATA from HMASTER_D one further cycle.
REQ-037 Fixed priority (ARB_MODE=0): HBUSREQ=4'b1010 -> HGRANT=4'b0010 held while requests persist; master 3 never granted.
REQ-038 Burst hold: master 1 owns, drives NONSEQ then 3 SEQ, master 2 requesting -> grant stays 1 until SEQ ends, then moves to 2.
REQ-039 Wait states: HREADY=0 for 3 cycles with master 2 requesting -> HGRANT, HMASTER, HWDATA source frozen; change on first edge with HREADY=1.
REQ-040 Lock: master 0 HLOCK=1, HBUSREQ=1, others requesting -> HMASTLOCK=1, grant held; drop HLOCK -> next arbitration grants master 1, HMASTLOCK=0 one cycle later.

Source files
------------

// File: rtl/ahb_lite_arbiter.sv
// AHB-Lite multi-master arbiter with fixed-priority or round-robin grant,
// burst/lock hold, and address/data-phase multiplexing to the slaves.
module ahb_lite_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int ARB_MODE    = 1,
    parameter int DEF_MASTER  = 0
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [NUM_MASTERS-1:0]    HBUSREQ,
    input  logic [NUM_MASTERS-1:0]    HLOCK,
    input  logic [2*NUM_MASTERS-1:0]  HTRANS_M,
    input  logic [AW*NUM_MASTERS-1:0] HADDR_M,
    input  logic [NUM_MASTERS-1:0]    HWRITE_M,
    input  logic [2*NUM_MASTERS-1:0]  HSIZE_M,
    input  logic [DW*NUM_MASTERS-1:0] HWDATA_M,
    input  logic                      HREADY,
    output logic [NUM_MASTERS-1:0]    HGRANT,
    output logic [3:0]                HMASTER,
    output logic                      HMASTLOCK,
    output logic [1:0]                HTRANS,
    output logic [AW-1:0]             HADDR,
    output logic                      HWRITE,
    output logic [1:0]                HSIZE,
    output logic [DW-1:0]             HWDATA
);

    localparam logic [3:0]             DEF_IDX   = 4'(DEF_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEF_MASTER;

    logic [3:0]             hmaster_d;
    logic [3:0]             last;
    logic [3:0]             grant_idx;
    logic                   grant_lock;
    logic                   grant_req;
    logic [3:0]             win_idx;
    logic                   win_valid;
    logic                   hold;
    logic [NUM_MASTERS-1:0] next_grant;

    always_comb begin
        grant_idx  = '0;
        grant_lock = 1'b0;
        grant_req  = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (HGRANT[i]) begin
                grant_idx  = 4'(i);
                grant_lock = HLOCK[i];
                grant_req  = HBUSREQ[i];
            end
        end
    end

    always_comb begin
        HTRANS = '0;
        HADDR  = '0;
        HWRITE = 1'b0;
        HSIZE  = '0;
        HWDATA = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (HMASTER == 4'(i)) begin
                HTRANS = HTRANS_M[2*i +: 2];
                HADDR  = HADDR_M[AW*i +: AW];
                HWRITE = HWRITE_M[i];
                HSIZE  = HSIZE_M[2*i +: 2];
            end
            if (hmaster_d == 4'(i)) begin
                HWDATA = HWDATA_M[DW*i +: DW];
            end
        end
    end

    // HTRANS[0] set means BUSY (01) or SEQ (11): the owner is mid-burst.
    assign hold = HTRANS[0] || (grant_lock && grant_req);

    // Round-robin: first pass searches above LAST, second pass wraps to 0..LAST.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = DEF_IDX;
        if (ARB_MODE == 0) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (!win_valid && HBUSREQ[i]) begin
                    win_valid = 1'b1;
                    win_idx   = 4'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (!win_valid && HBUSREQ[i] && (4'(i) > last)) begin
                    win_valid = 1'b1;
                    win_idx   = 4'(i);
                end
            end
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (!win_valid && HBUSREQ[i]) begin
                    win_valid = 1'b1;
                    win_idx   = 4'(i);
                end
            end
        end
    end

    always_comb begin
        next_grant = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            next_grant[i] = (win_idx == 4'(i));
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HGRANT    <= DEF_GRANT;
            HMASTER   <= DEF_IDX;
            hmaster_d <= DEF_IDX;
            HMASTLOCK <= 1'b0;
            last      <= DEF_IDX;
        end else if (HREADY) begin
            HMASTER   <= grant_idx;
            HMASTLOCK <= grant_lock;
            hmaster_d <= HMASTER;
            if (!hold) begin
                HGRANT <= next_grant;
                if (win_valid) begin
                    last <= win_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Self-checking bench: round-robin and fixed-priority arbiters share random
// stimulus and are compared each cycle against a behavioural reference model.
module tb_ahb_lite_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic            hready;
    logic [N-1:0]    busreq, lock, hwrite_m;
    logic [2*N-1:0]  htrans_m, hsize_m;
    logic [AW*N-1:0] haddr_m;
    logic [DW*N-1:0] hwdata_m;

    logic          req_in[N];
    logic          lk_in[N];
    logic          w_in[N];
    logic [1:0]    t_in[N];
    logic [1:0]    s_in[N];
    logic [AW-1:0] a_in[N];
    logic [DW-1:0] d_in[N];

    logic [N-1:0]  grant_o[2];
    logic [3:0]    master_o[2];
    logic          mlock_o[2];
    logic [1:0]    trans_o[2];
    logic [AW-1:0] addr_o[2];
    logic          write_o[2];
    logic [1:0]    size_o[2];
    logic [DW-1:0] wdata_o[2];

    int compared   = 0;
    int mismatched = 0;

    int m_g[2], m_own[2], m_own_d[2], m_last[2];
    bit m_lock[2];

    always #5 HCLK = ~HCLK;

    always_comb begin
        busreq = '0; lock = '0; hwrite_m = '0; htrans_m = '0;
        hsize_m = '0; haddr_m = '0; hwdata_m = '0;
        for (int i = 0; i < N; i++) begin
            busreq[i]          = req_in[i];
            lock[i]            = lk_in[i];
            hwrite_m[i]        = w_in[i];
            htrans_m[2*i +: 2] = t_in[i];
            hsize_m[2*i +: 2]  = s_in[i];
            haddr_m[AW*i +: AW] = a_in[i];
            hwdata_m[DW*i +: DW] = d_in[i];
        end
    end

    ahb_lite_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .ARB_MODE(1), .DEF_MASTER(0)) u_rr (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(busreq), .HLOCK(lock),
        .HTRANS_M(htrans_m), .HADDR_M(haddr_m), .HWRITE_M(hwrite_m), .HSIZE_M(hsize_m),
        .HWDATA_M(hwdata_m), .HREADY(hready), .HGRANT(grant_o[0]), .HMASTER(master_o[0]),
        .HMASTLOCK(mlock_o[0]), .HTRANS(trans_o[0]), .HADDR(addr_o[0]), .HWRITE(write_o[0]),
        .HSIZE(size_o[0]), .HWDATA(wdata_o[0])
    );

    ahb_lite_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .ARB_MODE(0), .DEF_MASTER(2)) u_fp (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(busreq), .HLOCK(lock),
        .HTRANS_M(htrans_m), .HADDR_M(haddr_m), .HWRITE_M(hwrite_m), .HSIZE_M(hsize_m),
        .HWDATA_M(hwdata_m), .HREADY(hready), .HGRANT(grant_o[1]), .HMASTER(master_o[1]),
        .HMASTLOCK(mlock_o[1]), .HTRANS(trans_o[1]), .HADDR(addr_o[1]), .HWRITE(write_o[1]),
        .HSIZE(size_o[1]), .HWDATA(wdata_o[1])
    );

    function automatic int mode_of(int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int def_of(int k);
        return (k == 0) ? 0 : 2;
    endfunction

    // Winner index for instance k, or -1 when nobody requests.
    function automatic int pick(int k);
        int c;
        for (int s = 0; s < N; s++) begin
            c = (mode_of(k) == 0) ? s : (m_last[k] + 1 + s) % N;
            if (req_in[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_g[k] = def_of(k); m_own[k] = def_of(k); m_own_d[k] = def_of(k);
            m_last[k] = def_of(k); m_lock[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (hready) begin
                int g;
                int w;
                bit hold;
                g    = m_g[k];
                hold = (t_in[m_own[k]] == 2'b01) || (t_in[m_own[k]] == 2'b11) ||
                       (lk_in[g] && req_in[g]);
                m_own_d[k] = m_own[k];
                m_own[k]   = g;
                m_lock[k]  = lk_in[g];
                if (!hold) begin
                    w = pick(k);
                    if (w < 0) m_g[k] = def_of(k);
                    else begin m_g[k] = w; m_last[k] = w; end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s/u%0d/grant", ph, k), 64'(grant_o[k]), 64'(4'(1) << m_g[k]));
            check($sformatf("%s/u%0d/hmaster", ph, k), 64'(master_o[k]), 64'(m_own[k]));
            check($sformatf("%s/u%0d/hmastlock", ph, k), 64'(mlock_o[k]), 64'(m_lock[k]));
            check($sformatf("%s/u%0d/htrans", ph, k), 64'(trans_o[k]), 64'(t_in[m_own[k]]));
            check($sformatf("%s/u%0d/haddr", ph, k), 64'(addr_o[k]), 64'(a_in[m_own[k]]));
            check($sformatf("%s/u%0d/hwrite", ph, k), 64'(write_o[k]), 64'(w_in[m_own[k]]));
            check($sformatf("%s/u%0d/hsize", ph, k), 64'(size_o[k]), 64'(s_in[m_own[k]]));
            check($sformatf("%s/u%0d/hwdata", ph, k), 64'(wdata_o[k]), 64'(d_in[m_own_d[k]]));
        end
    endtask

    task automatic randomize_inputs();
        int r;
        for (int i = 0; i < N; i++) begin
            req_in[i] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 6) == 0) lk_in[i] = ~lk_in[i];
            r = $urandom_range(0, 19);
            t_in[i] = (r < 12) ? 2'b10 : (r < 15) ? 2'b11 : (r < 17) ? 2'b01 : 2'b00;
            s_in[i] = 2'($urandom_range(0, 3));
            w_in[i] = 1'($urandom_range(0, 1));
            a_in[i] = $urandom;
            d_in[i] = $urandom;
        end
        hready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic directed_inputs(input logic [N-1:0] req);
        for (int i = 0; i < N; i++) begin
            req_in[i] = req[i];
            lk_in[i]  = 1'b0;
            t_in[i]   = 2'b10;
            s_in[i]   = 2'b10;
            w_in[i]   = 1'b1;
            a_in[i]   = 32'h1000_0000 + 32'(i);
            d_in[i]   = 32'hD000_0000 + 32'(i);
        end
        hready = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rr_exp[5];
        rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        HRESETn = 1'b0;
        for (int i = 0; i < N; i++) lk_in[i] = 1'b0;
        randomize_inputs();
        repeat (2) @(posedge HCLK);
        #1;
        model_reset();
        check("reset/rr_grant", 64'(grant_o[0]), 64'(4'b0001));
        check("reset/fp_grant", 64'(grant_o[1]), 64'(4'b0100));
        check_all("reset");

        // Round-robin rotation with everyone requesting single transfers.
        @(negedge HCLK);
        directed_inputs(4'b1111);
        HRESETn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge HCLK);
            model_edge();
            #1;
            check("rr_seq/grant", 64'(grant_o[0]), 64'(rr_exp[i]));
            check_all("rr_seq");
        end

        // Fixed priority: master 1 beats master 3 every time.
        directed_inputs(4'b1010);
        for (int i = 0; i < 4; i++) begin
            @(posedge HCLK);
            model_edge();
            #1;
            check("fixed/grant", 64'(grant_o[1]), 64'(4'b0010));
            check_all("fixed");
        end

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 200) begin
                #2;
                HRESETn = 1'b0;
                #1;
                model_reset();
                check("async_rst/grant", 64'(grant_o[0]), 64'(4'b0001));
                check("async_rst/hmaster", 64'(master_o[0]), 64'(0));
                check("async_rst/hmastlock", 64'(mlock_o[0]), 64'(0));
                check_all("async_rst");
                repeat (2) @(posedge HCLK);
                #1;
                check_all("in_rst");
                @(negedge HCLK);
                HRESETn = 1'b1;
            end
            randomize_inputs();
            @(posedge HCLK);
            model_edge();
            #1;
            check_all("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
